accum_mc_skid: RTL and testbench

//  AXI4-stream packet accumulator with NUM_CHANNELS interleaved channels selected by in_tid.

---
 rtl/accum_mc_skid_if.sv | 14 +
 rtl/accum_mc_skid.sv | 119 +++++++++++
 tb/tb_accum_mc_skid.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_mc_skid_if.sv
// accum_mc_skid_if: AXI4-stream beat bundle with producer (master) and consumer (slave) views
interface accum_mc_skid_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 2
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic                  tuser;
    modport master (output tvalid, tdata, tlast, tid, tuser, input tready);
    modport slave  (input tvalid, tdata, tlast, tid, tuser, output tready);
endinterface

// File: rtl/accum_mc_skid.sv
// accum_mc_skid: multi-channel stream accumulator with registered in_tready and a 2-entry output skid buffer
module accum_mc_skid #(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 32,
    parameter int NUM_CHANNELS = 4,
    parameter int SATURATE     = 0,
    parameter int EMIT_PARTIAL = 1
) (
    input logic             aclk,
    input logic             arst_n,
    accum_mc_skid_if.slave  in_i,
    accum_mc_skid_if.master out_o
);
    localparam int ID_WIDTH  = $clog2(NUM_CHANNELS);
    localparam int SUM_WIDTH = OUTPUT_WIDTH + 1;

    if (INPUT_WIDTH % 8 != 0 || OUTPUT_WIDTH % 8 != 0) begin : g_align_chk
        $fatal(1, "accum_mc_skid: data widths must be byte multiples");
    end
    if (OUTPUT_WIDTH < INPUT_WIDTH) begin : g_width_chk
        $fatal(1, "accum_mc_skid: OUTPUT_WIDTH must be >= INPUT_WIDTH");
    end
    if (NUM_CHANNELS < 2) begin : g_chan_chk
        $fatal(1, "accum_mc_skid: NUM_CHANNELS must be >= 2");
    end

    typedef struct packed {
        logic [OUTPUT_WIDTH-1:0] data;
        logic                    last;
        logic [ID_WIDTH-1:0]     id;
        logic                    user;
    } beat_t;

    logic [OUTPUT_WIDTH-1:0] acc_q [NUM_CHANNELS];
    logic [OUTPUT_WIDTH-1:0] acc_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] first_q, first_d, ovf_q, ovf_d;
    beat_t                   m_q, m_d, s_q, s_d, beat;
    logic                    m_vld_q, m_vld_d, s_vld_q, s_vld_d, rdy_q;
    logic                    accept, tid_ok, produce, drain, carry;
    logic [SUM_WIDTH-1:0]    sum;
    logic                    unused_tuser;

    assign unused_tuser = in_i.tuser;
    assign in_i.tready  = rdy_q;
    assign out_o.tvalid = m_vld_q;
    assign out_o.tdata  = m_q.data;
    assign out_o.tlast  = m_q.last;
    assign out_o.tid    = m_q.id;
    assign out_o.tuser  = m_q.user;

    // Per-channel sum for the accepted beat; out-of-range ids are swallowed without touching any channel
    always_comb begin
        accept    = in_i.tvalid && rdy_q;
        tid_ok    = 32'(in_i.tid) < NUM_CHANNELS;
        sum       = first_q[in_i.tid] ? SUM_WIDTH'(in_i.tdata)
                                      : {1'b0, acc_q[in_i.tid]} + SUM_WIDTH'(in_i.tdata);
        carry     = sum[OUTPUT_WIDTH];
        beat.data = (carry && SATURATE != 0) ? '1 : sum[OUTPUT_WIDTH-1:0];
        beat.last = in_i.tlast;
        beat.id   = in_i.tid;
        beat.user = ovf_q[in_i.tid] | carry;
        produce   = accept && tid_ok && (EMIT_PARTIAL != 0 || in_i.tlast);
        acc_d     = acc_q;
        first_d   = first_q;
        ovf_d     = ovf_q;
        if (accept && tid_ok) begin
            acc_d[in_i.tid]   = beat.data;
            first_d[in_i.tid] = in_i.tlast;
            ovf_d[in_i.tid]   = beat.user && !in_i.tlast;
        end
    end

    // M feeds the port; S only fills when a beat arrives while M is stalled, and refills M first on drain
    always_comb begin
        drain   = m_vld_q && out_o.tready;
        m_vld_d = m_vld_q;
        m_d     = m_q;
        s_vld_d = s_vld_q;
        s_d     = s_q;
        if (drain) begin
            m_vld_d = s_vld_q || produce;
            m_d     = s_vld_q ? s_q : beat;
            s_vld_d = s_vld_q && produce;
            s_d     = beat;
        end else if (produce && m_vld_q) begin
            s_vld_d = 1'b1;
            s_d     = beat;
        end else if (produce) begin
            m_vld_d = 1'b1;
            m_d     = beat;
        end
    end

    // Control state and buffer; ready is registered from next-cycle skid occupancy so out_tready never reaches in_tready
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            m_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
            rdy_q   <= 1'b0;
            first_q <= '1;
            ovf_q   <= '0;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            m_vld_q <= m_vld_d;
            s_vld_q <= s_vld_d;
            rdy_q   <= !s_vld_d;
            first_q <= first_d;
            ovf_q   <= ovf_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    // Running sums need no reset: first_q marks every channel stale after reset
    always_ff @(posedge aclk) begin
        acc_q <= acc_d;
    end
endmodule

// File: tb/tb_accum_mc_skid.sv
// tb_accum_mc_skid: table vectors, directed corner sequences and randomized traffic against a queue-based reference model
module tb_accum_mc_skid;
    logic aclk = 1'b0, arst_n = 1'b0;
    always #5 aclk = ~aclk;

    logic        vld = 1'b0, last = 1'b0;
    logic [15:0] data = '0;
    logic [1:0]  tid = '0;
    int          sel = 0;
    logic        ordy [4];
    logic        irdy [4], ovl [4], olst [4], ousr [4];
    logic [1:0]  oid [4];
    logic [31:0] od [4];
    int          checks = 0, errors = 0;

    accum_mc_skid_if #(.DATA_WIDTH(16), .ID_WIDTH(2)) in0 (), in1 (), in2 (), in3 (), out1 (), out2 ();
    accum_mc_skid_if #(.DATA_WIDTH(32), .ID_WIDTH(2)) out0 (), out3 ();

    accum_mc_skid u0 (.aclk(aclk), .arst_n(arst_n), .in_i(in0), .out_o(out0));
    accum_mc_skid #(.OUTPUT_WIDTH(16), .SATURATE(1)) u1 (.aclk(aclk), .arst_n(arst_n), .in_i(in1), .out_o(out1));
    accum_mc_skid #(.OUTPUT_WIDTH(16), .EMIT_PARTIAL(0)) u2 (.aclk(aclk), .arst_n(arst_n), .in_i(in2), .out_o(out2));
    accum_mc_skid #(.NUM_CHANNELS(3)) u3 (.aclk(aclk), .arst_n(arst_n), .in_i(in3), .out_o(out3));

    assign in0.tvalid = vld && sel == 0; assign in0.tdata = data; assign in0.tlast = last; assign in0.tid = tid; assign in0.tuser = 1'b0;
    assign in1.tvalid = vld && sel == 1; assign in1.tdata = data; assign in1.tlast = last; assign in1.tid = tid; assign in1.tuser = 1'b0;
    assign in2.tvalid = vld && sel == 2; assign in2.tdata = data; assign in2.tlast = last; assign in2.tid = tid; assign in2.tuser = 1'b0;
    assign in3.tvalid = vld && sel == 3; assign in3.tdata = data; assign in3.tlast = last; assign in3.tid = tid; assign in3.tuser = 1'b0;
    assign out0.tready = ordy[0]; assign out1.tready = ordy[1]; assign out2.tready = ordy[2]; assign out3.tready = ordy[3];
    assign irdy[0] = in0.tready; assign irdy[1] = in1.tready; assign irdy[2] = in2.tready; assign irdy[3] = in3.tready;
    assign ovl[0] = out0.tvalid; assign ovl[1] = out1.tvalid; assign ovl[2] = out2.tvalid; assign ovl[3] = out3.tvalid;
    assign od[0] = out0.tdata; assign od[1] = 32'(out1.tdata); assign od[2] = 32'(out2.tdata); assign od[3] = out3.tdata;
    assign olst[0] = out0.tlast; assign olst[1] = out1.tlast; assign olst[2] = out2.tlast; assign olst[3] = out3.tlast;
    assign oid[0] = out0.tid; assign oid[1] = out1.tid; assign oid[2] = out2.tid; assign oid[3] = out3.tid;
    assign ousr[0] = out0.tuser; assign ousr[1] = out1.tuser; assign ousr[2] = out2.tuser; assign ousr[3] = out3.tuser;

    // Reference model: configuration of each instance and per-channel packet state
    int     ow   [4] = '{32, 16, 16, 32};
    bit     sat  [4] = '{0, 1, 0, 0};
    bit     ep   [4] = '{1, 1, 0, 1};
    int     nch  [4] = '{4, 4, 4, 3};
    longint macc [4][4];
    bit     mfirst [4][4];
    bit     movf [4][4];

    typedef struct {
        int     k;
        longint d;
        bit     l;
        int     id;
        bit     u;
    } mb_t;
    mb_t q [$];

    typedef struct packed {
        logic [1:0]  k;
        logic [15:0] d;
        logic        l;
        logic [1:0]  id;
        logic        emit;
        logic [31:0] ed;
        logic        el;
        logic [1:0]  eid;
        logic        eu;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 4; c++) begin
                mfirst[k][c] = 1'b1;
                movf[k][c]   = 1'b0;
            end
    endtask

    task automatic model(input int k, input longint d, input bit l, input int id);
        longint lim, s;
        bit     c, u;
        if (id >= nch[k]) return;
        lim = longint'(1) << ow[k];
        s   = (mfirst[k][id] ? 64'd0 : macc[k][id]) + d;
        c   = s >= lim;
        if (c) s = sat[k] ? lim - 1 : s - lim;
        u = movf[k][id] | c;
        macc[k][id]   = s;
        mfirst[k][id] = l;
        movf[k][id]   = u && !l;
        if (ep[k] || l) q.push_back('{k, s, l, id, u});
    endtask

    task automatic send(input int k, input logic [15:0] d, input bit l, input logic [1:0] id);
        bit ok = 1'b0;
        sel = k; data = d; last = l; tid = id; vld = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge aclk);
            ok = irdy[k];
            @(posedge aclk);
        end
        chk("send_ready", ok, 1);
        if (ok) model(k, longint'(d), l, int'(id));
        #1;
    endtask

    task automatic row(input vec_t v);
        send(int'(v.k), v.d, v.l, v.id);
        vld = 1'b0;
        @(negedge aclk);
        chk("row_valid", ovl[v.k], v.emit);
        if (v.emit) begin
            chk("row_data", od[v.k], v.ed);
            chk("row_ctl", {olst[v.k], oid[v.k], ousr[v.k]}, {v.el, v.eid, v.eu});
        end
        @(posedge aclk); #1;
    endtask

    task automatic add(input int k, input int d, input bit l, input int id, input bit emit,
                       input int ed, input bit el, input int eid, input bit eu);
        tbl.push_back('{2'(k), 16'(d), l, 2'(id), emit, 32'(ed), el, 2'(eid), eu});
    endtask

    task automatic drain_wait();
        for (int n = 0; n < 100 && q.size() != 0; n++) begin
            @(posedge aclk); #1;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic rnd(input int k, input int nb);
        bit busy = 1'b1;
        fork
            begin
                for (int i = 0; i < nb; i++) begin
                    if ($urandom % 4 == 0) begin
                        vld = 1'b0;
                        @(posedge aclk); #1;
                    end
                    send(k, 16'($urandom), $urandom % 4 == 0, 2'($urandom));
                end
                vld  = 1'b0;
                busy = 1'b0;
            end
            while (busy) begin
                ordy[k] = $urandom % 4 != 0;
                @(posedge aclk); #1;
            end
        join
        ordy[k] = 1'b1;
        drain_wait();
    endtask

    // Output monitor: every handshake is matched against the model queue; stalled beats must hold
    logic        stall [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [35:0] hold  [4];
    always @(negedge aclk) begin
        for (int k = 0; k < 4; k++) begin
            if (stall[k]) chk("hold_stable", {ovl[k], od[k], olst[k], oid[k], ousr[k]}, {1'b1, hold[k]});
            if (arst_n && ovl[k] && ordy[k]) begin
                chk("beat_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    chk("beat_dut", k, q[0].k);
                    chk("beat_data", od[k], 32'(q[0].d));
                    chk("beat_ctl", {olst[k], oid[k], ousr[k]}, {q[0].l, 2'(q[0].id), q[0].u});
                    void'(q.pop_front());
                end
            end
            stall[k] <= arst_n && ovl[k] && !ordy[k];
            hold[k]  <= {od[k], olst[k], oid[k], ousr[k]};
        end
    end

    initial begin
        repeat (50000) @(posedge aclk);
        $display("FAIL watchdog: no finish within 50000 cycles");
        $fatal(1);
    end

    initial begin
        foreach (ordy[i]) ordy[i] = 1'b1;
        model_reset();
        add(0, 1, 0, 0, 1, 1, 0, 0, 0);
        add(0, 2, 0, 0, 1, 3, 0, 0, 0);
        add(0, 3, 1, 0, 1, 6, 1, 0, 0);
        add(0, 5, 0, 0, 1, 5, 0, 0, 0);
        add(0, 7, 0, 1, 1, 7, 0, 1, 0);
        add(0, 5, 1, 0, 1, 10, 1, 0, 0);
        add(0, 1, 1, 1, 1, 8, 1, 1, 0);
        add(1, 'hFFFF, 0, 0, 1, 'hFFFF, 0, 0, 0);
        add(1, 'h0002, 1, 0, 1, 'hFFFF, 1, 0, 1);
        add(1, 'h0003, 1, 0, 1, 'h0003, 1, 0, 0);
        add(2, 'hFFFF, 0, 0, 0, 0, 0, 0, 0);
        add(2, 'h0002, 1, 0, 1, 'h0001, 1, 0, 1);
        add(2, 'h0003, 1, 0, 1, 'h0003, 1, 0, 0);
        add(2, 4, 0, 2, 0, 0, 0, 0, 0);
        add(2, 4, 0, 2, 0, 0, 0, 0, 0);
        add(2, 4, 1, 2, 1, 12, 1, 2, 0);
        add(3, 9, 1, 3, 0, 0, 0, 0, 0);
        add(3, 4, 1, 0, 1, 4, 1, 0, 0);

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        for (int k = 0; k < 4; k++) chk("reset_state", {ovl[k], irdy[k], olst[k], ousr[k]}, 0);
        @(posedge aclk); #1;
        arst_n = 1'b1;
        @(negedge aclk);
        chk("ready_at_release", irdy[0], 0);
        @(negedge aclk);
        chk("ready_after_edge", irdy[0], 1);
        @(posedge aclk); #1;

        foreach (tbl[i]) row(tbl[i]);

        fork
            for (int i = 0; i < 8; i++) send(0, 16'(10 + i), i >= 6, 2'(i % 2));
            begin
                ordy[0] = 1'b0;
                repeat (2) @(posedge aclk);
                @(negedge aclk);
                chk("bp_ready_low", irdy[0], 0);
                chk("bp_buffered", q.size(), 2);
                repeat (3) @(posedge aclk);
                #1;
                ordy[0] = 1'b1;
            end
        join
        vld = 1'b0;
        drain_wait();

        ordy[0] = 1'b0;
        send(0, 16'd1, 1'b0, 2'd0);
        send(0, 16'd2, 1'b0, 2'd0);
        vld = 1'b0;
        @(negedge aclk);
        chk("skid_full_ready", irdy[0], 0);
        @(posedge aclk); #1;
        arst_n = 1'b0;
        @(posedge aclk); #1;
        arst_n = 1'b1;
        model_reset();
        @(negedge aclk);
        chk("reset_flush", ovl[0], 0);
        @(posedge aclk); #1;
        ordy[0] = 1'b1;
        row('{2'd0, 16'd9, 1'b1, 2'd0, 1'b1, 32'd9, 1'b1, 2'd0, 1'b0});

        for (int k = 0; k < 4; k++) rnd(k, 150);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
